cls381_rd_collect: RTL and testbench
====================================

Name: cls381_rd_collect

Overview:
- Read-side counterpart to the CLS381 configuration writer.
- Consumes the stream of data bytes returned by i2c_ctrl while it polls the sensor's colour registers (0x0D–0x15), one byte per register read.
- Checks that the address sequence is correct and assembles the bytes into three 20-bit channel words: green 0x0D–0x0F, red 0x10–0x12, blue 0x13–0x15.
- Publishes the three words atomically, with a frame-valid pulse, to downstream colour-classification logic.

Parameters:
- TIMEOUT_MAX, 16'd2000: maximum idle i2c_clk cycles allowed between consecutive bytes of one frame (2 ms at 1 MHz).

Ports:
- i2c_clk, input, 1: clock shared with i2c_ctrl.
- sys_rst_n, input, 1: asynchronous reset, active-low.
- rd_valid, input, 1: one-cycle pulse; rd_addr and rd_data are valid in that cycle.
- rd_addr, input, 8: register address that rd_data was read from.
- rd_data, input, 8: byte read from the sensor.
- green, output, 20: assembled green channel.
- red, output, 20: assembled red channel.
- blue, output, 20: assembled blue channel.
- data_valid, output, 1: one-cycle pulse; green, red and blue have just been updated.
- frame_err, output, 1: one-cycle pulse; the current partial frame was discarded.

Behaviour:
- Reset: green, red, blue = 20'd0; data_valid = 0; frame_err = 0; byte index = 0; timeout counter = 0; byte shadow registers = 0.
- Expected address sequence, index 0..8: 0x0F, 0x0E, 0x0D, 0x12, 0x11, 0x10, 0x15, 0x14, 0x13. Within each channel the MSB byte comes first.
- MSB byte: only bits [3:0] are used; bits [7:4] are masked. Channel word = {msb[3:0], mid[7:0], lsb[7:0]}.
- States:
  - IDLE (index 0): waiting for 0x0F. rd_valid with any other address is silently ignored, with no frame_err.
  - COLLECT (index 1..8): accept each byte whose rd_addr matches the expected address at the current index; store it in the shadow register; index++.
- Frame completion: on the cycle the index-8 byte (0x13) is accepted, the next i2c_clk edge:
  - loads green, red and blue from the shadows and the just-accepted byte simultaneously;
  - drives data_valid = 1 for exactly one cycle;
  - returns the block to IDLE.
  - Latency from the last rd_valid to data_valid = 1 cycle.
- Address mismatch in COLLECT:
  - frame_err pulses for 1 cycle (registered, next edge).
  - Shadows are discarded; outputs are unchanged.
  - If the mismatching address is 0x0F, that byte is taken as index 0 of a new frame and the next expected address is 0x0E. Otherwise the block returns to IDLE.
- Timeout:
  - The counter runs only in COLLECT and clears on every accepted rd_valid.
  - When it reaches TIMEOUT_MAX-1: frame_err pulses, the block returns to IDLE and the counter clears.
  - If rd_valid arrives in the same cycle the counter hits TIMEOUT_MAX-1, rd_valid takes priority and no timeout occurs.
- Outputs hold their values between frames; they never show partial frames.
- data_valid and frame_err are never asserted in the same cycle.
- Reset asserted mid-frame: everything returns to reset values immediately; no pulse is generated.
- rd_valid in the cycle directly after frame completion is processed normally.

Optional Feature:
- Macro: CLS381_AVG_EN.
- Defined:
  - Each channel keeps a 4-entry history of completed frames.
  - Outputs = (sum of the 4 entries) >> 2, using a 22-bit sum, truncated.
  - The first completed frame after reset fills all 4 entries with itself.
  - Each later frame replaces the oldest entry.
  - data_valid timing is unchanged; the average is registered in the same update cycle.
- Undefined: outputs are the raw assembled values; no history storage exists.

Test Plan:
- Nominal frame: bytes in order (0x0F:0xA5, 0x0E:0x12, 0x0D:0x34, 0x12:0x03, 0x11:0x56, 0x10:0x78, 0x15:0xF1, 0x14:0x9A, 0x13:0xBC), 50-cycle gaps.
  - Response: one cycle after the last byte, data_valid = 1, green = 0x51234, red = 0x35678, blue = 0x19ABC; frame_err never asserted.
- Mismatch: after 0x0F, 0x0E, send address 0x12.
  - Response: frame_err pulse; outputs unchanged; the following full nominal frame is accepted normally.
- Resync: after 0x0F, 0x0E, send 0x0F:0x02, then the remaining 8 bytes of a frame.
  - Response: frame_err pulse, then data_valid with the green MSB nibble = 0x2.
- Timeout: TIMEOUT_MAX = 100; send 0x0F, then nothing for 100 cycles.
  - Response: frame_err pulses exactly 100 cycles after that byte.
  - Also: a byte arriving on the boundary cycle is accepted and no timeout occurs.
- Reset mid-frame: assert sys_rst_n = 0 after 5 bytes.
  - Response: outputs = 0, no pulses; a fresh frame afterwards completes correctly.
- CLS381_AVG_EN: frames with green = 0x00100, then 0x00500.
  - Response: green = 0x00100, then 0x00200.

Source files
------------

// File: rtl/cls381_rd_collect.sv
// CLS381 colour read collector: checks the 0x0F..0x13 register read order and publishes green/red/blue 20-bit words atomically.
// Optional `define CLS381_AVG_EN replaces raw outputs with a 4-frame running average per channel.
module cls381_rd_collect #(
  parameter logic [15:0] TIMEOUT_MAX = 16'd2000
) (
  input  logic        i2c_clk,
  input  logic        sys_rst_n,
  input  logic        rd_valid,
  input  logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic [19:0] green,
  output logic [19:0] red,
  output logic [19:0] blue,
  output logic        data_valid,
  output logic        frame_err
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [15:0] cnt, cnt_nx;
  logic        err_nx, done_nx, sh_we, sh_clr;
  logic [2:0]  sh_sel;
  logic [7:0]  sh [8];
  logic [19:0] w_g, w_r, w_b;

  function automatic logic [7:0] exp_addr(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h0F;
      4'd1:    return 8'h0E;
      4'd2:    return 8'h0D;
      4'd3:    return 8'h12;
      4'd4:    return 8'h11;
      4'd5:    return 8'h10;
      4'd6:    return 8'h15;
      4'd7:    return 8'h14;
      default: return 8'h13;
    endcase
  endfunction

  // Only the low nibble of the MSB byte belongs to the 20-bit word.
  function automatic logic [19:0] chan(input logic [7:0] msb, input logic [7:0] mid,
                                       input logic [7:0] lsb);
    return 20'({msb & 8'h0F, mid, lsb});
  endfunction

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      idx        <= 4'd0;
      cnt        <= 16'd0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      data_valid <= done_nx;
      frame_err  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    err_nx   = 1'b0;
    done_nx  = 1'b0;
    sh_we    = 1'b0;
    sh_clr   = 1'b0;
    sh_sel   = idx[2:0];
    case (state)
      IDLE: begin
        cnt_nx = 16'd0;
        if (rd_valid && rd_addr == 8'h0F) begin
          state_nx = COLLECT;
          idx_nx   = 4'd1;
          sh_we    = 1'b1;
          sh_sel   = 3'd0;
        end
      end
      COLLECT: begin
        if (rd_valid) begin
          cnt_nx = 16'd0;
          if (rd_addr == exp_addr(idx)) begin
            if (idx == 4'd8) begin
              done_nx  = 1'b1;
              state_nx = IDLE;
              idx_nx   = 4'd0;
            end else begin
              sh_we  = 1'b1;
              idx_nx = idx + 4'd1;
            end
          end else begin
            err_nx = 1'b1;
            sh_clr = 1'b1;
            // A stray 0x0F is the start of a new frame rather than noise.
            if (rd_addr == 8'h0F) begin
              sh_we  = 1'b1;
              sh_sel = 3'd0;
              idx_nx = 4'd1;
            end else begin
              state_nx = IDLE;
              idx_nx   = 4'd0;
            end
          end
        end else if (cnt == TIMEOUT_MAX - 16'd1) begin
          err_nx   = 1'b1;
          sh_clr   = 1'b1;
          state_nx = IDLE;
          idx_nx   = 4'd0;
          cnt_nx   = 16'd0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < 8; k++) sh[k] <= 8'h00;
    end else begin
      if (sh_clr)
        for (int k = 0; k < 8; k++) sh[k] <= 8'h00;
      if (sh_we)
        sh[sh_sel] <= rd_data;
    end
  end

  // The last byte bypasses the shadows so the words land one cycle after it.
  assign w_g = chan(sh[0], sh[1], sh[2]);
  assign w_r = chan(sh[3], sh[4], sh[5]);
  assign w_b = chan(sh[6], sh[7], rd_data);

`ifdef CLS381_AVG_EN
  logic [19:0] hist [3][4];
  logic [19:0] nw [3];
  logic [19:0] avg_nx [3];
  logic [1:0]  ptr;
  logic        filled;

  function automatic logic [19:0] avg4(input logic [19:0] a, input logic [19:0] b,
                                       input logic [19:0] c, input logic [19:0] d);
    logic [21:0] s;
    s = 22'(a) + 22'(b) + 22'(c) + 22'(d);
    return 20'(s >> 2);
  endfunction

  always_comb begin
    nw[0] = w_g;
    nw[1] = w_r;
    nw[2] = w_b;
    for (int c = 0; c < 3; c++)
      avg_nx[c] = avg4((ptr == 2'd0) ? nw[c] : hist[c][0],
                       (ptr == 2'd1) ? nw[c] : hist[c][1],
                       (ptr == 2'd2) ? nw[c] : hist[c][2],
                       (ptr == 2'd3) ? nw[c] : hist[c][3]);
  end

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < 4; k++) hist[c][k] <= 20'd0;
      ptr    <= 2'd0;
      filled <= 1'b0;
      green  <= 20'd0;
      red    <= 20'd0;
      blue   <= 20'd0;
    end else if (done_nx) begin
      if (!filled) begin
        // First frame seeds the whole history so the average starts at its value.
        for (int c = 0; c < 3; c++)
          for (int k = 0; k < 4; k++) hist[c][k] <= nw[c];
        filled <= 1'b1;
        green  <= nw[0];
        red    <= nw[1];
        blue   <= nw[2];
      end else begin
        for (int c = 0; c < 3; c++) hist[c][ptr] <= nw[c];
        ptr   <= ptr + 2'd1;
        green <= avg_nx[0];
        red   <= avg_nx[1];
        blue  <= avg_nx[2];
      end
    end
  end
`else
  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      green <= 20'd0;
      red   <= 20'd0;
      blue  <= 20'd0;
    end else if (done_nx) begin
      green <= w_g;
      red   <= w_r;
      blue  <= w_b;
    end
  end
`endif

endmodule

// File: tb/tb_cls381_rd_collect.sv
// Bench for cls381_rd_collect: frame table plus hand sequences for mismatch, resync, timeout and reset.
// Expected words go to a queue and are compared when data_valid pulses (honours CLS381_AVG_EN).
module tb_cls381_rd_collect;

  logic        i2c_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_addr = 8'h00;
  logic [7:0]  rd_data = 8'h00;
  logic [19:0] green, red, blue;
  logic        data_valid, frame_err;

  int total = 0;
  int bad = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int n_push = 0;
  logic [59:0] exp_q [$];
  logic [59:0] last_out = '0;
  logic [7:0]  addr_seq [9] = '{8'h0F, 8'h0E, 8'h0D, 8'h12, 8'h11, 8'h10, 8'h15, 8'h14, 8'h13};

  typedef struct {
    logic [71:0] bytes;
    int          gap;
    logic [59:0] expv;
  } vec_t;
  vec_t vt [3];

  always #5 i2c_clk = ~i2c_clk;

  cls381_rd_collect #(.TIMEOUT_MAX(16'd100)) dut (
    .i2c_clk    (i2c_clk),
    .sys_rst_n  (sys_rst_n),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .green      (green),
    .red        (red),
    .blue       (blue),
    .data_valid (data_valid),
    .frame_err  (frame_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

`ifdef CLS381_AVG_EN
  logic [19:0] mh [3][4];
  bit          mfill = 1'b0;
  int          mptr = 0;
`endif

  task automatic model_reset();
`ifdef CLS381_AVG_EN
    mfill = 1'b0;
    mptr  = 0;
`endif
    last_out = '0;
  endtask

  task automatic model(input logic [59:0] raw, output logic [59:0] o);
`ifdef CLS381_AVG_EN
    logic [21:0] s;
    for (int c = 0; c < 3; c++) begin
      if (!mfill) for (int k = 0; k < 4; k++) mh[c][k] = raw[59-20*c -: 20];
      else mh[c][mptr] = raw[59-20*c -: 20];
      s = 22'(mh[c][0]) + 22'(mh[c][1]) + 22'(mh[c][2]) + 22'(mh[c][3]);
      o[59-20*c -: 20] = s[21:2];
    end
    if (!mfill) mfill = 1'b1;
    else mptr = (mptr + 1) % 4;
`else
    o = raw;
`endif
  endtask

  task automatic push_exp(input logic [59:0] raw);
    logic [59:0] m;
    model(raw, m);
    exp_q.push_back(m);
    last_out = m;
    n_push++;
  endtask

  task automatic tick();
    @(posedge i2c_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] a, input logic [7:0] d);
    rd_valid = 1'b1;
    rd_addr  = a;
    rd_data  = d;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] bytes, input int gap, input logic [59:0] raw);
    for (int k = 0; k < 9; k++) begin
      if (k == 8) push_exp(raw);
      send_byte(addr_seq[k], bytes[71-8*k -: 8]);
      if (k < 8) repeat (gap) tick();
    end
    chk("dv_latency", {63'd0, data_valid}, 64'd1);
  endtask

  // Scoreboard side: every data_valid pulse consumes one expected frame.
  always @(negedge i2c_clk) begin
    if (data_valid || frame_err) begin
      total++;
      if (data_valid && frame_err) begin
        bad++;
        $display("FAIL dv_fe_overlap actual=11 required=one_of");
      end
    end
    if (frame_err) fe_cnt++;
    if (data_valid) begin
      dv_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dv_unexpected actual=%h required=none", {green, red, blue});
      end else begin
        logic [59:0] e;
        e = exp_q.pop_front();
        chk("sb_green", 64'(green), 64'(e[59:40]));
        chk("sb_red",   64'(red),   64'(e[39:20]));
        chk("sb_blue",  64'(blue),  64'(e[19:0]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, dv0;
    bit early;

    vt[0] = '{72'hA5_12_34_03_56_78_F1_9A_BC, 50, {20'h51234, 20'h35678, 20'h19ABC}};
    vt[1] = '{72'hFF_FF_FF_F0_00_01_0A_BC_DE, 1,  {20'hFFFFF, 20'h00001, 20'hABCDE}};
    vt[2] = '{72'h00_00_00_00_00_00_00_00_00, 0,  {20'h00000, 20'h00000, 20'h00000}};

    repeat (3) tick();
    chk("rst_green", 64'(green), 64'd0);
    chk("rst_red",   64'(red),   64'd0);
    chk("rst_blue",  64'(blue),  64'd0);
    chk("rst_dv",    64'(data_valid), 64'd0);
    chk("rst_fe",    64'(frame_err),  64'd0);
    sys_rst_n = 1'b1;
    tick();

    // Table frames; each next frame starts in the data_valid cycle of the previous one.
    fe0 = fe_cnt;
    for (int i = 0; i < 3; i++) send_frame(vt[i].bytes, vt[i].gap, vt[i].expv);
    tick();
    chk("dv_one_cycle", 64'(data_valid), 64'd0);
    chk("table_no_fe", 64'(fe_cnt - fe0), 64'd0);

    // Stray address in IDLE is ignored silently.
    send_byte(8'h13, 8'h55);
    tick();
    chk("idle_ignore_fe", 64'(fe_cnt - fe0), 64'd0);

    // Mismatch after two good bytes.
    send_byte(8'h0F, 8'hA5);
    send_byte(8'h0E, 8'h12);
    send_byte(8'h12, 8'h03);
    chk("mm_fe", 64'(frame_err), 64'd1);
    chk("mm_hold", 64'({green, red, blue}), 64'(last_out));
    tick();
    chk("mm_fe_pulse", 64'(frame_err), 64'd0);
    send_frame(vt[0].bytes, 2, vt[0].expv);

    // Resync on a stray 0x0F.
    tick();
    send_byte(8'h0F, 8'hA5);
    send_byte(8'h0E, 8'h12);
    send_byte(8'h0F, 8'h02);
    chk("rs_fe", 64'(frame_err), 64'd1);
    send_byte(8'h0E, 8'h12);
    send_byte(8'h0D, 8'h34);
    send_byte(8'h12, 8'h03);
    send_byte(8'h11, 8'h56);
    send_byte(8'h10, 8'h78);
    send_byte(8'h15, 8'hF1);
    send_byte(8'h14, 8'h9A);
    push_exp({20'h21234, 20'h35678, 20'h19ABC});
    send_byte(8'h13, 8'hBC);
    chk("rs_dv", 64'(data_valid), 64'd1);

    // Timeout fires exactly 100 edges after the byte edge.
    tick();
    fe0 = fe_cnt;
    send_byte(8'h0F, 8'h11);
    early = 1'b0;
    repeat (99) begin
      tick();
      if (frame_err) early = 1'b1;
    end
    chk("tmo_early", 64'(early), 64'd0);
    tick();
    chk("tmo_fire", 64'(frame_err), 64'd1);
    chk("tmo_hold", 64'({green, red, blue}), 64'(last_out));
    tick();

    // A byte on the boundary cycle wins over the timeout.
    fe0 = fe_cnt;
    send_byte(8'h0F, 8'hA5);
    repeat (99) tick();
    send_byte(8'h0E, 8'h12);
    chk("tmo_boundary_fe", 64'(frame_err), 64'd0);
    for (int k = 2; k < 9; k++) begin
      if (k == 8) push_exp(vt[0].expv);
      send_byte(addr_seq[k], vt[0].bytes[71-8*k -: 8]);
    end
    chk("tmo_boundary_dv", 64'(data_valid), 64'd1);
    chk("tmo_boundary_nofe", 64'(fe_cnt - fe0), 64'd0);

    // Reset in the middle of a frame.
    tick();
    fe0 = fe_cnt;
    dv0 = dv_cnt;
    for (int k = 0; k < 5; k++) send_byte(addr_seq[k], vt[1].bytes[71-8*k -: 8]);
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst_out", 64'({green, red, blue}), 64'd0);
    repeat (3) tick();
    chk("mrst_pulses", 64'((fe_cnt - fe0) + (dv_cnt - dv0)), 64'd0);
    sys_rst_n = 1'b1;
    tick();
    send_frame(vt[1].bytes, 0, vt[1].expv);

`ifdef CLS381_AVG_EN
    tick();
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    tick();
    sys_rst_n = 1'b1;
    tick();
    send_frame(72'h00_01_00_00_00_00_00_00_00, 1, {20'h00100, 20'h0, 20'h0});
    chk("avg_first", 64'(green), 64'h00100);
    send_frame(72'h00_05_00_00_00_00_00_00_00, 1, {20'h00500, 20'h0, 20'h0});
    chk("avg_second", 64'(green), 64'h00200);
`endif

    repeat (3) tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("dv_count", 64'(dv_cnt), 64'(n_push));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
